// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and data access (DM).
//   Round-robin arbitration on ties, one access at a time, variable wait for
//   mem_ready_i, and abort with bus_err_o after TIMEOUT cycles without an answer.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   if_req_i, if_addr_i   fetch request (always a read), held until if_done_o
//   if_rdata_o, if_done_o fetched word (registered), one-cycle completion pulse
//   dm_req_i, dm_we_i,    data request, held with we/addr/wdata until dm_done_o
//   dm_addr_i, dm_wdata_i
//   dm_rdata_o, dm_done_o data read value (registered), one-cycle completion pulse
//   mem_en_o              high for the whole ACCESS state
//   mem_we_o, mem_addr_o, latched attributes of the current access
//   mem_wdata_o
//   mem_rdata_i,          memory read data / completion, sampled only in ACCESS
//   mem_ready_i
//   bus_err_o             one-cycle pulse together with done on a timed-out access
//   busy_o                high whenever the arbiter is not idle
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_done_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              bus_err_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              grant_s;
   logic              pick_s;
   logic              rd_load_s;
   logic [DATA_W-1:0] rd_val_s;

   // Next-state logic: arbitration, access sequencing, timeout and read capture
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      grant_s    = 1'b0;
      pick_s     = OWN_IF;
      rd_load_s  = 1'b0;
      rd_val_s   = '0;

      case (state_q)
         ST_IDLE: begin
            // On a tie the requester that did not own the port last time wins
            if (if_req_i && dm_req_i) begin
               grant_s = 1'b1;
               pick_s  = (last_q == OWN_IF) ? OWN_DM : OWN_IF;
            end else if (dm_req_i) begin
               grant_s = 1'b1;
               pick_s  = OWN_DM;
            end else if (if_req_i) begin
               grant_s = 1'b1;
               pick_s  = OWN_IF;
            end else begin
               grant_s = 1'b0;
            end
            if (grant_s) begin
               owner_d = pick_s;
               last_d  = pick_s;
               addr_d  = (pick_s == OWN_DM) ? dm_addr_i : if_addr_i;
               we_d    = (pick_s == OWN_DM) ? dm_we_i : 1'b0;
               wdata_d = (pick_s == OWN_DM) ? dm_wdata_i : '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // Ready is checked first so it wins over a coinciding timeout
            if (mem_ready_i) begin
               err_d     = 1'b0;
               rd_load_s = ~we_q;
               rd_val_s  = mem_rdata_i;
               state_d   = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d     = 1'b1;
               rd_load_s = ~we_q;
               rd_val_s  = '0;
               state_d   = ST_RESP;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = ST_ACCESS;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rd_load_s && (owner_q == OWN_DM)) begin
         dm_rdata_d = rd_val_s;
      end else if (rd_load_s) begin
         if_rdata_d = rd_val_s;
      end else begin
         dm_rdata_d = dm_rdata_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         last_q     <= OWN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   // Outputs are decodes of registered state only
   assign mem_en_o    = (state_q == ST_ACCESS);
   assign mem_we_o    = (state_q == ST_ACCESS) & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_done_o   = (state_q == ST_RESP) & (owner_q == OWN_IF);
   assign dm_done_o   = (state_q == ST_RESP) & (owner_q == OWN_DM);
   assign bus_err_o   = (state_q == ST_RESP) & err_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: a table of single transactions with
//   hand-computed latency/error/rdata, plus hand-written sequences for the
//   round-robin tie order and reset during an access.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        if_req_i;
   logic [15:0] if_addr_i;
   logic [15:0] if_rdata_o;
   logic        if_done_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [15:0] dm_addr_i;
   logic [15:0] dm_wdata_i;
   logic [15:0] dm_rdata_o;
   logic        dm_done_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic [15:0] mem_rdata_i;
   logic        mem_ready_i;
   logic        bus_err_o;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_done_o   (if_done_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_rdata_o  (dm_rdata_o),
      .dm_done_o   (dm_done_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i),
      .bus_err_o   (bus_err_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // delay = wait cycles before mem_ready (-1: never answers)
   // lat   = clock edges from raising req to seeing done
   typedef struct {
      logic        is_dm;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          delay;
      logic [15:0] rdata;
      int          lat;
      logic        err;
      logic [15:0] exp_if;
      logic [15:0] exp_dm;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      if_req_i    = 1'b0;
      if_addr_i   = 16'h0000;
      dm_req_i    = 1'b0;
      dm_we_i     = 1'b0;
      dm_addr_i   = 16'h0000;
      dm_wdata_i  = 16'h0000;
      mem_rdata_i = 16'h0000;
      mem_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   acc;
      int   lat;
      logic seen;
      logic err;
      logic bad_acc;
      logic stray;
      acc     = 0;
      lat     = 0;
      seen    = 1'b0;
      err     = 1'b0;
      bad_acc = 1'b0;
      stray   = 1'b0;
      if (v.is_dm) begin
         dm_req_i   = 1'b1;
         dm_we_i    = v.we;
         dm_addr_i  = v.addr;
         dm_wdata_i = v.wdata;
      end else begin
         if_req_i  = 1'b1;
         if_addr_i = v.addr;
      end
      mem_ready_i = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(posedge clk_i);
         #1;
         mem_ready_i = 1'b0;
         mem_rdata_i = 16'hDEAD;
         if (mem_en_o) begin
            if (mem_we_o !== v.we || mem_addr_o !== v.addr) bad_acc = 1'b1;
            if (v.we && mem_wdata_o !== v.wdata) bad_acc = 1'b1;
            if (v.delay == acc) begin
               mem_ready_i = 1'b1;
               mem_rdata_i = v.rdata;
            end
            acc++;
         end
         if ((v.is_dm ? if_done_o : dm_done_o) === 1'b1) stray = 1'b1;
         if ((v.is_dm ? dm_done_o : if_done_o) === 1'b1) begin
            seen     = 1'b1;
            lat      = c;
            err      = bus_err_o;
            if_req_i = 1'b0;
            dm_req_i = 1'b0;
         end else if (bus_err_o === 1'b1) begin
            stray = 1'b1;
         end
      end
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
      $display("vector %0d", idx);
      chk("latency", lat, v.lat);
      chk("bus_err", err, v.err);
      chk("access_cycles", acc, v.lat - 1);
      chk("access_attrs", bad_acc, 1'b0);
      chk("stray_done", stray, 1'b0);
      chk("if_rdata", if_rdata_o, v.exp_if);
      chk("dm_rdata", dm_rdata_o, v.exp_dm);
      @(posedge clk_i);
      #1;
      chk("busy_after", busy_o, 1'b0);
   endtask

   initial begin
      logic [3:0] ord;
      int         n;
      int         overlap;
      logic       stray;

      //            dm    we    addr      wdata     dly rdata     lat err   exp_if    exp_dm
      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000,  0, 16'hBEEF,  2, 1'b0, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234,  3, 16'h0000,  5, 1'b0, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h0000,  1, 16'hCAFE,  3, 1'b0, 16'hBEEF, 16'hCAFE};
      vecs[3] = '{1'b1, 1'b0, 16'h0400, 16'h0000, -1, 16'h0000, 16, 1'b1, 16'hBEEF, 16'h0000};
      vecs[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 14, 16'h5A5A, 16, 1'b0, 16'h5A5A, 16'h0000};
      vecs[5] = '{1'b1, 1'b0, 16'h0500, 16'h0000,  2, 16'h1357,  4, 1'b0, 16'h5A5A, 16'h1357};
      vecs[6] = '{1'b1, 1'b1, 16'h0600, 16'h9999, -1, 16'h0000, 16, 1'b1, 16'h5A5A, 16'h1357};
      vecs[7] = '{1'b0, 1'b0, 16'h0030, 16'h0000, -1, 16'h0000, 16, 1'b1, 16'h0000, 16'h1357};

      // Reset state
      do_reset();
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 16'h0000);
      chk("rst_dones", {if_done_o, dm_done_o, bus_err_o}, 3'b000);
      chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 32'h0000_0000);

      // Single transactions from the table
      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], i);
      end

      // Tie right after reset: dm, if, dm, if; ready held high even in IDLE/RESP
      do_reset();
      mem_ready_i = 1'b1;
      mem_rdata_i = 16'hABCD;
      if_addr_i   = 16'h0100;
      dm_addr_i   = 16'h0300;
      dm_we_i     = 1'b0;
      if_req_i    = 1'b1;
      dm_req_i    = 1'b1;
      ord         = 4'b0000;
      n           = 0;
      overlap     = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(posedge clk_i);
         #1;
         if (if_done_o && dm_done_o) overlap++;
         if (dm_done_o || if_done_o) begin
            ord[n] = dm_done_o;
            n++;
         end
      end
      if_req_i    = 1'b0;
      dm_req_i    = 1'b0;
      mem_ready_i = 1'b0;
      chk("tie_grants", n, 4);
      chk("tie_order", ord, 4'b0101);
      chk("tie_overlap", overlap, 0);
      chk("tie_rdata", {if_rdata_o, dm_rdata_o}, 32'hABCD_ABCD);

      // Reset in the 2nd ACCESS cycle of a fetch drops it
      do_reset();
      if_req_i  = 1'b1;
      if_addr_i = 16'h0040;
      @(posedge clk_i);
      #1;
      chk("abort_access1", mem_en_o, 1'b1);
      @(posedge clk_i);
      #1;
      chk("abort_access2", mem_en_o, 1'b1);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("abort_mem_en", mem_en_o, 1'b0);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_if_rdata", if_rdata_o, 16'h0000);
      reset_i  = 1'b0;
      if_req_i = 1'b0;
      stray    = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i);
         #1;
         if (if_done_o || dm_done_o || bus_err_o || busy_o) stray = 1'b1;
      end
      chk("abort_no_done", stray, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
